// File: rtl/sp_pkg.sv
// Shared opcode/func encodings and the EX->WB pipeline bundle for the SP pipe2 core.
package sp_pkg;

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_ANDI = 6'd1;
  localparam logic [5:0] OP_ORI  = 6'd2;
  localparam logic [5:0] OP_ADDI = 6'd3;
  localparam logic [5:0] OP_SUBI = 6'd4;
  localparam logic [5:0] OP_LW   = 6'd5;
  localparam logic [5:0] OP_SW   = 6'd6;
  localparam logic [5:0] OP_BEQ  = 6'd7;
  localparam logic [5:0] OP_BNE  = 6'd8;

  localparam logic [5:0] F_AND = 6'd0;
  localparam logic [5:0] F_OR  = 6'd1;
  localparam logic [5:0] F_ADD = 6'd2;
  localparam logic [5:0] F_SUB = 6'd3;
  localparam logic [5:0] F_SLT = 6'd4;
  localparam logic [5:0] F_SLL = 6'd5;
  localparam logic [5:0] F_SRL = 6'd6;

  // Widest supported data path; narrower cores zero-extend into the result field.
  localparam int RES_W = 64;

  // Everything the WB stage needs to retire one instruction.
  typedef struct packed {
    logic             valid;
    logic             wen;
    logic [4:0]       dst;
    logic [RES_W-1:0] result;
    logic             is_lw;
    logic             illegal;
  } ex_wb_t;

endpackage

// File: rtl/sp_pipe2_if.sv
// Instruction-fetch and data-memory bus of the SP pipe2 core.
interface sp_pipe2_if #(
  parameter int DATA_W = 32,
  parameter int MEM_AW = 12
);

  logic              in_valid;
  logic [31:0]       inst;
  logic [31:0]       inst_addr;
  logic              out_valid;
  logic              illegal;
  logic              mem_wen;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  // Core side
  modport master (
    input  in_valid, inst, mem_dout,
    output inst_addr, out_valid, illegal, mem_wen, mem_addr, mem_din
  );

  // Instruction source / data memory side
  modport slave (
    output in_valid, inst, mem_dout,
    input  inst_addr, out_valid, illegal, mem_wen, mem_addr, mem_din
  );

endinterface

// File: rtl/sp_alu.sv
// Combinational ALU: R-type by func, I-type by opcode, plus equality for branches.
module sp_alu
  import sp_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [5:0]        op_i,
  input  logic [5:0]        func_i,
  input  logic [4:0]        shamt_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_o,
  output logic              eq_o,
  output logic              illegal_o
);

  // Result select; unknown R-type funcs produce zero and raise illegal.
  always_comb begin
    result_o  = '0;
    illegal_o = 1'b0;
    case (op_i)
      OP_R: begin
        case (func_i)
          F_AND:   result_o = a_i & b_i;
          F_OR:    result_o = a_i | b_i;
          F_ADD:   result_o = a_i + b_i;
          F_SUB:   result_o = a_i - b_i;
          F_SLT:   result_o = ($signed(a_i) < $signed(b_i)) ? DATA_W'(1) : '0;
          F_SLL:   result_o = a_i << shamt_i;
          F_SRL:   result_o = a_i >> shamt_i;
          default: illegal_o = 1'b1;
        endcase
      end
      OP_ANDI:             result_o = a_i & b_i;
      OP_ORI:              result_o = a_i | b_i;
      OP_ADDI, OP_LW, OP_SW: result_o = a_i + b_i;
      OP_SUBI:             result_o = a_i - b_i;
      default:             result_o = '0;
    endcase
  end

  assign eq_o = (a_i == b_i);

endmodule

// File: rtl/sp_pipe2.sv
// Two-stage (EX/WB) SP core: PC, register file, EX->WB register and WB->EX bypass.
module sp_pipe2
  import sp_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_NUM = 32,
  parameter int MEM_AW  = 12,
  parameter int R0_ZERO = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  sp_pipe2_if.master bus
);

  localparam int IDX_W = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

  logic [DATA_W-1:0] r [0:REG_NUM-1];

  logic [31:0] pc_q, pc_d;
  ex_wb_t      wb_q, wb_d;
  logic        outValid_q;
  logic        illegal_q;

  logic [5:0]  opcode, funcF;
  logic [4:0]  rsF, rtF, rdF, shamtF;
  logic [15:0] imm16;
  logic [IDX_W-1:0] rsIdx, rtIdx, rdIdx, dstIdx, wbIdx;
  logic [DATA_W-1:0] immExt, rsVal, rtVal, bVal, aluRes, wbVal;
  logic [31:0] pcOffset;
  logic        aluEq, aluIllegal, isWrite, taken, dropR0, wbHit;

  assign opcode = bus.inst[31:26];
  assign rsF    = bus.inst[25:21];
  assign rtF    = bus.inst[20:16];
  assign rdF    = bus.inst[15:11];
  assign shamtF = bus.inst[10:6];
  assign funcF  = bus.inst[5:0];
  assign imm16  = bus.inst[15:0];

  assign rsIdx = rsF[IDX_W-1:0];
  assign rtIdx = rtF[IDX_W-1:0];
  assign rdIdx = rdF[IDX_W-1:0];
  assign wbIdx = wb_q.dst[IDX_W-1:0];

  // andi/ori use a zero-extended immediate so they can build bit masks.
  assign immExt = ((opcode == OP_ANDI) || (opcode == OP_ORI)) ?
                  DATA_W'(imm16) : DATA_W'($signed(imm16));
  assign pcOffset = {{14{imm16[15]}}, imm16, 2'b00};

  // A load's data only arrives during WB, so the bypass picks mem_dout for it.
  assign wbVal = wb_q.is_lw ? bus.mem_dout : wb_q.result[DATA_W-1:0];
  assign wbHit = wb_q.valid && wb_q.wen;

  // Operand read with WB->EX forwarding; r0 reads zero when hard-wired.
  always_comb begin
    rsVal = r[rsIdx];
    rtVal = r[rtIdx];
    if ((R0_ZERO != 0) && (rsIdx == '0)) rsVal = '0;
    if ((R0_ZERO != 0) && (rtIdx == '0)) rtVal = '0;
    if (wbHit && (wbIdx == rsIdx)) rsVal = wbVal;
    if (wbHit && (wbIdx == rtIdx)) rtVal = wbVal;
  end

  assign bVal = ((opcode == OP_R) || (opcode == OP_BEQ) || (opcode == OP_BNE)) ?
                rtVal : immExt;

  sp_alu #(.DATA_W(DATA_W)) u_alu (
    .op_i      (opcode),
    .func_i    (funcF),
    .shamt_i   (shamtF),
    .a_i       (rsVal),
    .b_i       (bVal),
    .result_o  (aluRes),
    .eq_o      (aluEq),
    .illegal_o (aluIllegal)
  );

  assign isWrite = ((opcode == OP_R) && !aluIllegal) ||
                   ((opcode >= OP_ANDI) && (opcode <= OP_LW));
  assign dstIdx  = (opcode == OP_R) ? rdIdx : rtIdx;
  assign dropR0  = (R0_ZERO != 0) && (dstIdx == '0);
  assign taken   = ((opcode == OP_BEQ) && aluEq) || ((opcode == OP_BNE) && !aluEq);

  // Address wraps silently to the memory width.
  assign bus.mem_addr = aluRes[MEM_AW-1:0];
  assign bus.mem_din  = rtVal;
  assign bus.mem_wen  = rst_n && bus.in_valid && (opcode == OP_SW);

  // Next PC: hold during bubbles, branch target when taken, else sequential.
  always_comb begin
    pc_d = pc_q;
    if (bus.in_valid) pc_d = taken ? (pc_q + 32'd4 + pcOffset) : (pc_q + 32'd4);
  end

  // Build the EX->WB bundle; r0 writes are dropped here so they never bypass.
  always_comb begin
    wb_d         = '0;
    wb_d.valid   = bus.in_valid;
    wb_d.wen     = bus.in_valid && isWrite && !dropR0;
    wb_d.dst     = 5'(dstIdx);
    wb_d.result  = RES_W'(aluRes);
    wb_d.is_lw   = (opcode == OP_LW);
    wb_d.illegal = aluIllegal;
  end

  // Pipeline and status registers; reset drops whatever is in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= '0;
      wb_q       <= '0;
      outValid_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      wb_q       <= wb_d;
      outValid_q <= wb_q.valid;
      illegal_q  <= wb_q.valid && wb_q.illegal;
    end
  end

  // Register file write at the end of WB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) r[i] <= '0;
    end else if (wbHit) begin
      r[wbIdx] <= wbVal;
    end
  end

  generate
    if (DATA_W < RES_W) begin : g_unusedRes
      logic unusedResBits;
      assign unusedResBits = ^wb_q.result[RES_W-1:DATA_W];
    end
  endgenerate

  assign bus.inst_addr = pc_q;
  assign bus.out_valid = outValid_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_sp_pipe2.sv
// Directed bench for sp_pipe2 (R0_ZERO=1) with a synchronous-read data memory model.
module tb_sp_pipe2;

  localparam logic [5:0] T_ADDI = 6'd3, T_ORI = 6'd2, T_LW = 6'd5, T_SW = 6'd6;
  localparam logic [5:0] T_BEQ = 6'd7, T_BNE = 6'd8;
  localparam logic [5:0] T_ADD = 6'd2, T_SUB = 6'd3, T_SLT = 6'd4, T_SLL = 6'd5, T_SRL = 6'd6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sp_pipe2_if #(.DATA_W(32), .MEM_AW(12)) bus ();

  sp_pipe2 #(.DATA_W(32), .REG_NUM(32), .MEM_AW(12), .R0_ZERO(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] dmem [0:4095];
  logic        preloadWe;
  logic [11:0] preloadAddr;
  logic [31:0] preloadData;

  // Data memory: read data registered one cycle after the address, read-before-write.
  always @(posedge clk) begin
    if (preloadWe) dmem[preloadAddr] <= preloadData;
    else if (bus.mem_wen) dmem[bus.mem_addr] <= bus.mem_din;
    bus.mem_dout <= dmem[bus.mem_addr];
  end

  int errors = 0;
  int checks = 0;
  logic [15:0] ovLog;
  logic [15:0] illLog;

  function automatic logic [31:0] rType(input logic [5:0] func, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] shamt);
    return {6'd0, rs, rt, rd, shamt, func};
  endfunction

  function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one cycle from a negedge, then log the retire flags seen at the next negedge.
  task automatic applyStimulus(input logic v, input logic [31:0] ins);
    bus.in_valid = v;
    bus.inst     = ins;
    @(negedge clk);
    ovLog  = {ovLog[14:0], bus.out_valid};
    illLog = {illLog[14:0], bus.illegal};
  endtask

  task automatic doReset();
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.inst     = '0;
    @(negedge clk);
    rst_n  = 1'b1;
    ovLog  = '0;
    illLog = '0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.inst     = '0;
    preloadWe    = 1'b1;
    preloadAddr  = 12'd10;
    preloadData  = 32'h1234;
    ovLog        = '0;
    illLog       = '0;
    @(negedge clk);
    preloadWe = 1'b0;

    // Reset state
    checkOutput("rst_pc", bus.inst_addr, 32'd0);
    checkOutput("rst_ov", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_ill", 32'(bus.illegal), 32'd0);
    checkOutput("rst_wen", 32'(bus.mem_wen), 32'd0);
    for (int i = 0; i < 32; i++) checkOutput($sformatf("rst_r%0d", i), dut.r[i], 32'd0);
    rst_n = 1'b1;

    // Dependent ALU chain, back-to-back
    applyStimulus(1'b1, iType(T_ADDI, 5'd1, 5'd0, 16'd5));
    applyStimulus(1'b1, iType(T_ADDI, 5'd2, 5'd1, 16'd3));
    applyStimulus(1'b1, rType(T_SUB, 5'd3, 5'd2, 5'd1, 5'd0));
    applyStimulus(1'b1, rType(T_SLT, 5'd4, 5'd1, 5'd2, 5'd0));
    applyStimulus(1'b0, 32'd0);
    applyStimulus(1'b0, 32'd0);
    checkOutput("chain_ov", 32'(ovLog[5:0]), 32'b011110);
    checkOutput("chain_r1", dut.r[1], 32'd5);
    checkOutput("chain_r2", dut.r[2], 32'd8);
    checkOutput("chain_r3", dut.r[3], 32'd3);
    checkOutput("chain_r4", dut.r[4], 32'd1);
    checkOutput("chain_pc", bus.inst_addr, 32'd16);

    // Load-use, store with bypassed data, then store-after-load to one address
    applyStimulus(1'b1, iType(T_ADDI, 5'd5, 5'd0, 16'd10));
    applyStimulus(1'b1, iType(T_LW, 5'd6, 5'd5, 16'd0));
    applyStimulus(1'b1, rType(T_ADD, 5'd7, 5'd6, 5'd6, 5'd0));
    bus.in_valid = 1'b1;
    bus.inst     = iType(T_SW, 5'd7, 5'd5, 16'd1);
    #1;
    checkOutput("sw_wen", 32'(bus.mem_wen), 32'd1);
    checkOutput("sw_addr", 32'(bus.mem_addr), 32'd11);
    checkOutput("sw_din", bus.mem_din, 32'h2468);
    @(negedge clk);
    applyStimulus(1'b1, iType(T_ADDI, 5'd8, 5'd0, 16'h55));
    applyStimulus(1'b1, iType(T_LW, 5'd9, 5'd5, 16'd1));
    applyStimulus(1'b1, iType(T_SW, 5'd8, 5'd5, 16'd1));
    applyStimulus(1'b0, 32'd0);
    applyStimulus(1'b0, 32'd0);
    checkOutput("lu_r5", dut.r[5], 32'd10);
    checkOutput("lu_r6", dut.r[6], 32'h1234);
    checkOutput("lu_r7", dut.r[7], 32'h2468);
    checkOutput("lu_r9_old", dut.r[9], 32'h2468);
    checkOutput("lu_mem11", dmem[11], 32'h55);

    // Branches and immediate extension
    doReset();
    applyStimulus(1'b1, iType(T_ADDI, 5'd1, 5'd0, 16'd5));
    applyStimulus(1'b1, iType(T_BEQ, 5'd1, 5'd1, 16'hFFFF));
    checkOutput("beq_loop1", bus.inst_addr, 32'd4);
    applyStimulus(1'b1, iType(T_BEQ, 5'd1, 5'd1, 16'hFFFF));
    checkOutput("beq_loop2", bus.inst_addr, 32'd4);
    applyStimulus(1'b1, iType(T_BNE, 5'd1, 5'd1, 16'd4));
    checkOutput("bne_nt", bus.inst_addr, 32'd8);
    applyStimulus(1'b1, iType(T_BNE, 5'd0, 5'd1, 16'd4));
    checkOutput("bne_t", bus.inst_addr, 32'd28);
    applyStimulus(1'b1, iType(T_ORI, 5'd2, 5'd0, 16'hFFFF));
    applyStimulus(1'b1, iType(T_ADDI, 5'd3, 5'd0, 16'hFFFF));
    applyStimulus(1'b1, iType(6'd9, 5'd4, 5'd1, 16'd5));
    checkOutput("nop_pc", bus.inst_addr, 32'd40);
    applyStimulus(1'b0, 32'd0);
    applyStimulus(1'b0, 32'd0);
    checkOutput("ori_zext", dut.r[2], 32'h0000FFFF);
    checkOutput("addi_sext", dut.r[3], 32'hFFFFFFFF);
    checkOutput("nop_ill", 32'(illLog[7:0]), 32'd0);

    // Bubbles: in_valid 1,0,0,1
    doReset();
    applyStimulus(1'b1, iType(T_ADDI, 5'd8, 5'd0, 16'd1));
    checkOutput("bub_pc0", bus.inst_addr, 32'd4);
    applyStimulus(1'b0, iType(T_ADDI, 5'd8, 5'd0, 16'd7));
    checkOutput("bub_pc1", bus.inst_addr, 32'd4);
    applyStimulus(1'b0, iType(T_SW, 5'd8, 5'd0, 16'd3));
    checkOutput("bub_pc2", bus.inst_addr, 32'd4);
    applyStimulus(1'b1, iType(T_ADDI, 5'd9, 5'd0, 16'd2));
    checkOutput("bub_pc3", bus.inst_addr, 32'd8);
    applyStimulus(1'b0, 32'd0);
    applyStimulus(1'b0, 32'd0);
    checkOutput("bub_ov", 32'(ovLog[5:0]), 32'b010010);
    checkOutput("bub_r8", dut.r[8], 32'd1);
    checkOutput("bub_r9", dut.r[9], 32'd2);

    // Hard-wired r0, illegal func, shifts
    applyStimulus(1'b1, iType(T_ADDI, 5'd1, 5'd0, 16'd9));
    applyStimulus(1'b1, iType(T_ADDI, 5'd0, 5'd0, 16'd7));
    applyStimulus(1'b1, rType(T_ADD, 5'd1, 5'd0, 5'd0, 5'd0));
    applyStimulus(1'b0, 32'd0);
    applyStimulus(1'b0, 32'd0);
    checkOutput("r0_zero", dut.r[0], 32'd0);
    checkOutput("r0_nobyp", dut.r[1], 32'd0);
    illLog = '0;
    applyStimulus(1'b1, iType(T_ADDI, 5'd2, 5'd0, 16'd3));
    applyStimulus(1'b1, rType(6'd7, 5'd2, 5'd2, 5'd2, 5'd0));
    applyStimulus(1'b0, 32'd0);
    applyStimulus(1'b0, 32'd0);
    checkOutput("ill_flag", 32'(illLog[3:0]), 32'b0010);
    checkOutput("ill_nowr", dut.r[2], 32'd3);
    applyStimulus(1'b1, iType(T_ADDI, 5'd10, 5'd0, 16'd1));
    applyStimulus(1'b1, rType(T_SLL, 5'd10, 5'd10, 5'd0, 5'd31));
    applyStimulus(1'b1, rType(T_SRL, 5'd11, 5'd10, 5'd0, 5'd31));
    applyStimulus(1'b0, 32'd0);
    applyStimulus(1'b0, 32'd0);
    checkOutput("sll31", dut.r[10], 32'h80000000);
    checkOutput("srl31", dut.r[11], 32'd1);

    // Reset mid-run while an instruction sits in WB
    applyStimulus(1'b1, iType(T_ADDI, 5'd12, 5'd0, 16'd7));
    applyStimulus(1'b1, iType(T_ADDI, 5'd13, 5'd0, 16'd9));
    doReset();
    checkOutput("mid_pc", bus.inst_addr, 32'd0);
    checkOutput("mid_ov", 32'(bus.out_valid), 32'd0);
    checkOutput("mid_r12", dut.r[12], 32'd0);
    checkOutput("mid_r13", dut.r[13], 32'd0);
    applyStimulus(1'b0, 32'd0);
    checkOutput("mid_ov2", 32'(bus.out_valid), 32'd0);
    applyStimulus(1'b1, iType(T_ADDI, 5'd14, 5'd0, 16'd4));
    checkOutput("mid_fetch", bus.inst_addr, 32'd4);
    applyStimulus(1'b0, 32'd0);
    applyStimulus(1'b0, 32'd0);
    checkOutput("mid_r14", dut.r[14], 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
